// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg: shared encodings and helpers for the byte-serial memory controller.
package mem_ctrl_pkg;
  localparam logic [1:0] MEM_NOP = 2'b00, MEM_BYTE = 2'b01, MEM_HALF = 2'b10, MEM_WORD = 2'b11;
  localparam logic [31:0] ZERO_WORD = 32'h0;
  localparam logic [7:0] ZERO_BYTE = 8'h0;
  localparam logic RST_ENABLE = 1'b0;
  typedef enum logic [2:0] {IDLE, IF_RD, MEM_RD, MEM_WR, DONE} state_t;
  function automatic logic [2:0] nbytes(input logic [1:0] sel);
    return sel == MEM_BYTE ? 3'd1 : sel == MEM_HALF ? 3'd2 : sel == MEM_WORD ? 3'd4 : 3'd0;
  endfunction
  function automatic logic [31:0] extend(input logic [31:0] d, input logic [1:0] sel, input logic sign);
    return sel == MEM_BYTE ? {{24{sign & d[7]}}, d[7:0]} :
           sel == MEM_HALF ? {{16{sign & d[15]}}, d[15:0]} : d;
  endfunction
endpackage

// File: rtl/mem_ctrl_rd_pipe.sv
// mem_rd_pipe: read-latency shift pipe of valid+byte-index tags driving byte-lane capture enables.
module mem_rd_pipe
  import mem_ctrl_pkg::*;
#(
  parameter int READ_LATENCY = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       in_v,
  input  logic [1:0] in_idx,
  output logic [3:0] cap,
  output logic       out_v,
  output logic [1:0] out_idx
);
  logic [READ_LATENCY-1:0] v;
  logic [1:0] idx [READ_LATENCY];
  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE || clr) begin
      v <= '0;
      for (int i = 0; i < READ_LATENCY; i++) idx[i] <= 2'd0;
    end else begin
      v[0] <= in_v;
      idx[0] <= in_idx;
      for (int i = 1; i < READ_LATENCY; i++) begin
        v[i] <= v[i-1];
        idx[i] <= idx[i-1];
      end
    end
  end
  always_comb begin
    out_v = v[READ_LATENCY-1];
    out_idx = idx[READ_LATENCY-1];
    cap = out_v ? 4'd1 << out_idx : 4'd0;
  end
endmodule

// File: rtl/mem_ctrl.sv
// mem_ctrl: arbitrates IF and MEM accesses onto a byte-wide RAM port, one byte per bus cycle.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int READ_LATENCY = 2,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_flush,
  output logic              if_done,
  output logic [31:0]       if_data,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [1:0]        mem_sel,
  input  logic              mem_sign,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_wdata,
  output logic              mem_done,
  output logic [31:0]       mem_rdata,
  output logic [ADDR_W-1:0] mem_a,
  output logic              mem_wr,
  output logic [7:0]        mem_dout,
  input  logic [7:0]        mem_din
);
  state_t state, state_n;
  logic [ADDR_W-1:0] addr, addr_n, a_n;
  logic [31:0] wd, wd_n, acc, acc_n, acc_m, if_data_n, rdata_n;
  logic [1:0] sel, sel_n, iss_idx, idx_n, out_idx;
  logic [2:0] cnt, cnt_n, nb;
  logic sign, sign_n, iss, iss_n, wr_n, if_done_n, mem_done_n, clr, out_v, last;
  logic [7:0] dout_n;
  logic [3:0] cap;
  mem_rd_pipe #(.READ_LATENCY(READ_LATENCY)) u_pipe (
    .clk(clk), .rst(rst), .clr(clr), .in_v(iss), .in_idx(iss_idx),
    .cap(cap), .out_v(out_v), .out_idx(out_idx)
  );
  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      state <= IDLE;
      addr <= '0;
      wd <= ZERO_WORD;
      acc <= ZERO_WORD;
      sel <= MEM_NOP;
      sign <= 1'b0;
      cnt <= 3'd0;
      iss <= 1'b0;
      iss_idx <= 2'd0;
      mem_a <= '0;
      mem_wr <= 1'b0;
      mem_dout <= ZERO_BYTE;
      if_done <= 1'b0;
      if_data <= ZERO_WORD;
      mem_done <= 1'b0;
      mem_rdata <= ZERO_WORD;
    end else begin
      state <= state_n;
      addr <= addr_n;
      wd <= wd_n;
      acc <= acc_n;
      sel <= sel_n;
      sign <= sign_n;
      cnt <= cnt_n;
      iss <= iss_n;
      iss_idx <= idx_n;
      mem_a <= a_n;
      mem_wr <= wr_n;
      mem_dout <= dout_n;
      if_done <= if_done_n;
      if_data <= if_data_n;
      mem_done <= mem_done_n;
      mem_rdata <= rdata_n;
    end
  end
  always_comb begin
    nb = nbytes(sel);
    acc_m = {cap[3] ? mem_din : acc[31:24], cap[2] ? mem_din : acc[23:16],
             cap[1] ? mem_din : acc[15:8], cap[0] ? mem_din : acc[7:0]};
    last = out_v && {1'b0, out_idx} == nb - 3'd1;
    state_n = state;
    addr_n = addr;
    wd_n = wd;
    acc_n = acc_m;
    sel_n = sel;
    sign_n = sign;
    cnt_n = cnt;
    iss_n = 1'b0;
    idx_n = 2'd0;
    a_n = '0;
    wr_n = 1'b0;
    dout_n = ZERO_BYTE;
    if_done_n = 1'b0;
    if_data_n = if_data;
    mem_done_n = 1'b0;
    rdata_n = mem_rdata;
    clr = 1'b0;
    case (state)
      IDLE: begin
        if (mem_req) begin
          addr_n = mem_addr;
          wd_n = mem_wdata;
          sel_n = mem_sel;
          sign_n = mem_sign;
          acc_n = ZERO_WORD;
          cnt_n = 3'd1;
          if (mem_sel == MEM_NOP) begin
            state_n = DONE;
            mem_done_n = 1'b1;
            rdata_n = ZERO_WORD;
          end else begin
            state_n = mem_we ? MEM_WR : MEM_RD;
            a_n = mem_addr;
            wr_n = mem_we;
            dout_n = mem_we ? mem_wdata[7:0] : ZERO_BYTE;
            iss_n = !mem_we;
          end
        end else if (if_req && !if_flush) begin
          state_n = IF_RD;
          addr_n = if_addr;
          sel_n = MEM_WORD;
          sign_n = 1'b0;
          acc_n = ZERO_WORD;
          cnt_n = 3'd1;
          a_n = if_addr;
          iss_n = 1'b1;
        end
      end
      MEM_WR: begin
        if (cnt == nb) begin
          state_n = DONE;
          mem_done_n = 1'b1;
          rdata_n = ZERO_WORD;
        end else begin
          a_n = addr + ADDR_W'(cnt);
          wr_n = 1'b1;
          dout_n = wd[{cnt[1:0], 3'b000} +: 8];
          cnt_n = cnt + 3'd1;
        end
      end
      IF_RD, MEM_RD: begin
        // A flush drops the tags of bytes still in flight so late data is never captured.
        if (state == IF_RD && if_flush) begin
          state_n = IDLE;
          clr = 1'b1;
        end else begin
          if (cnt < nb) begin
            a_n = addr + ADDR_W'(cnt);
            iss_n = 1'b1;
            idx_n = cnt[1:0];
            cnt_n = cnt + 3'd1;
          end
          if (last) begin
            state_n = DONE;
            if_done_n = state == IF_RD;
            mem_done_n = state == MEM_RD;
            if_data_n = state == IF_RD ? acc_m : if_data;
            rdata_n = state == MEM_RD ? extend(acc_m, sel, sign) : mem_rdata;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end
endmodule
